// File: rtl/branch_pred_pkg.sv
// Shared types and helpers for the branch predictors.
// Latency: n/a (package only).
// Backpressure: n/a.
package branch_pred_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counters sweep to strongly-not-taken.
  localparam logic [3:0] CNT_RESET = 4'd0;

  // Saturating up/down step for a counter of 'width' bits (1..4).
  function automatic logic [3:0] sat_update(input logic [3:0] counter,
                                            input logic taken,
                                            input int unsigned width);
    logic [3:0] cmax;
    cmax = 4'((32'd1 << width) - 32'd1);
    if (taken) begin
      sat_update = (counter >= cmax) ? cmax : counter + 4'd1;
    end else begin
      sat_update = (counter == 4'd0) ? 4'd0 : counter - 4'd1;
    end
  endfunction

endpackage

// File: rtl/btb_array.sv
// Branch target buffer: {valid, tag, target} per entry, swept clear, tag compare on read.
// Latency: read combinational; write visible the cycle after the write edge.
// Backpressure: none; one write per cycle, clear takes priority over write.
module btb_array
  import branch_pred_pkg::*;
#(
  parameter int INDEX_WIDTH = 6,
  parameter int OFFSET      = 2,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                   clock,
  input  logic                   clear_en,
  input  logic [INDEX_WIDTH-1:0] clear_index,
  input  logic                   write_en,
  input  logic [31:0]            write_addr,
  input  logic [31:0]            write_target,
  input  logic [31:0]            read_addr,
  input  logic                   read_en,
  output logic                   hit,
  output logic [31:0]            target
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;

  logic                 valid_mem  [ENTRIES];
  logic [TAG_WIDTH-1:0] tag_mem    [ENTRIES];
  logic [31:0]          target_mem [ENTRIES];

  logic [INDEX_WIDTH-1:0] w_index, r_index;
  logic [TAG_WIDTH-1:0]   w_tag, r_tag;
  logic                   unused_btb;

  assign w_index = write_addr[INDEX_WIDTH+OFFSET-1:OFFSET];
  assign w_tag   = write_addr[OFFSET+INDEX_WIDTH+TAG_WIDTH-1:OFFSET+INDEX_WIDTH];
  assign r_index = read_addr[INDEX_WIDTH+OFFSET-1:OFFSET];
  assign r_tag   = read_addr[OFFSET+INDEX_WIDTH+TAG_WIDTH-1:OFFSET+INDEX_WIDTH];
  assign unused_btb = ^{write_addr, read_addr};

  // Sweep clears one valid bit per cycle; otherwise install taken branches.
  always_ff @(posedge clock) begin
    if (clear_en) begin
      valid_mem[clear_index] <= 1'b0;
    end else if (write_en) begin
      valid_mem[w_index]  <= 1'b1;
      tag_mem[w_index]    <= w_tag;
      target_mem[w_index] <= write_target;
    end
  end

  // Hit only when initialised, valid and tag matches; target zero on miss.
  always_comb begin
    hit    = read_en && valid_mem[r_index] && (tag_mem[r_index] == r_tag);
    target = hit ? target_mem[r_index] : 32'd0;
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor (PHT indexed by PC xor GHR) with optional BTB (GSHARE_PREDICTOR_BTB_EN).
// Latency: prediction combinational; updates and GHR shift visible the next cycle; ready after 2^INDEX_WIDTH sweep cycles.
// Backpressure: none; updates are dropped while ready is low.
module gshare_predictor
  import branch_pred_pkg::*;
#(
  parameter int INDEX_WIDTH   = 6,
  parameter int OFFSET        = 2,
  parameter int COUNTER_WIDTH = 2,
  parameter int HISTORY_WIDTH = 6,
  parameter int TAG_WIDTH     = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addressToPredict,
  output logic        prediction,
  output logic [(HISTORY_WIDTH > 0 ? HISTORY_WIDTH : 1)-1:0] predictHistory,
  output logic        ready,
  input  logic        updateEnable,
  input  logic [31:0] addressToWrite,
  input  logic [(HISTORY_WIDTH > 0 ? HISTORY_WIDTH : 1)-1:0] updateHistory,
  input  logic        branchoutcome,
  input  logic [31:0] branchTarget,
  output logic [31:0] predictedTarget,
  output logic        targetHit
);

  localparam int HW      = (HISTORY_WIDTH > 0) ? HISTORY_WIDTH : 1;
  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(ENTRIES - 1);

  state_t                   state, state_next;
  logic [INDEX_WIDTH-1:0]   sweep_index, sweep_next;
  logic [COUNTER_WIDTH-1:0] pht [ENTRIES];
  logic [HW-1:0]            ghr;
  logic [INDEX_WIDTH-1:0]   pred_hist_ext, upd_hist_ext, pred_index, upd_index;
  logic [COUNTER_WIDTH-1:0] pred_counter, upd_counter;
  logic [3:0]               upd_wide;
  logic                     accept;
  logic                     unused_top;

  assign ready          = (state == RUN);
  assign accept         = updateEnable && ready;
  assign predictHistory = ghr;
  assign unused_top     = ^{addressToPredict, addressToWrite, branchTarget, updateHistory};

  generate
    if (HISTORY_WIDTH > 0) begin : g_hist
      assign pred_hist_ext = INDEX_WIDTH'(ghr);
      assign upd_hist_ext  = INDEX_WIDTH'(updateHistory);
      // Non-speculative history: shift in each accepted resolved outcome.
      always_ff @(posedge clock) begin
        if (reset) begin
          ghr <= '0;
        end else if (accept) begin
          ghr <= HW'({ghr, branchoutcome});
        end
      end
    end else begin : g_no_hist
      assign pred_hist_ext = '0;
      assign upd_hist_ext  = '0;
      assign ghr           = '0;
    end
  endgenerate

  assign pred_index   = addressToPredict[INDEX_WIDTH+OFFSET-1:OFFSET] ^ pred_hist_ext;
  assign upd_index    = addressToWrite[INDEX_WIDTH+OFFSET-1:OFFSET] ^ upd_hist_ext;
  assign pred_counter = pht[pred_index];
  assign prediction   = ready & pred_counter[COUNTER_WIDTH-1];

  // Next counter value for the resolved branch.
  always_comb begin
    upd_wide    = sat_update(4'(pht[upd_index]), branchoutcome, COUNTER_WIDTH);
    upd_counter = upd_wide[COUNTER_WIDTH-1:0];
  end

  // PHT write port: sweep clear during INIT, resolved-branch update in RUN.
  always_ff @(posedge clock) begin
    if (state == INIT) begin
      pht[sweep_index] <= COUNTER_WIDTH'(CNT_RESET);
    end else if (accept) begin
      pht[upd_index] <= upd_counter;
    end
  end

  // FSM state and sweep pointer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= INIT;
      sweep_index <= '0;
    end else begin
      state       <= state_next;
      sweep_index <= sweep_next;
    end
  end

  // Sweep every entry once, then run until the next reset.
  always_comb begin
    state_next = state;
    sweep_next = sweep_index;
    if (state == INIT) begin
      sweep_next = sweep_index + 1'b1;
      if (sweep_index == LAST_INDEX) begin
        state_next = RUN;
      end
    end
  end

`ifdef GSHARE_PREDICTOR_BTB_EN
  btb_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .OFFSET      (OFFSET),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_btb (
    .clock        (clock),
    .clear_en     (state == INIT),
    .clear_index  (sweep_index),
    .write_en     (accept && branchoutcome),
    .write_addr   (addressToWrite),
    .write_target (branchTarget),
    .read_addr    (addressToPredict),
    .read_en      (ready),
    .hit          (targetHit),
    .target       (predictedTarget)
  );
`else
  assign targetHit       = 1'b0;
  assign predictedTarget = 32'd0;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench: a bimodal instance (no history) and a 6-bit-history gshare instance.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
// Expected values are hand-computed per directed step.
module tb_gshare_predictor;
  import branch_pred_pkg::*;

`ifdef GSHARE_PREDICTOR_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  localparam int F_READY = 0, F_PRED = 1, F_HIST = 2, F_HIT = 3, F_TGT = 4;

  logic clk, rst;

  // Bimodal instance (HISTORY_WIDTH = 0)
  logic [31:0] b_pa, b_wa, b_tgt, b_ptgt;
  logic        b_en, b_out, b_pred, b_ready, b_hit;
  logic [0:0]  b_hist, b_phist;

  // Gshare instance (HISTORY_WIDTH = 6)
  logic [31:0] g_pa, g_wa, g_tgt, g_ptgt;
  logic        g_en, g_out, g_pred, g_ready, g_hit;
  logic [5:0]  g_hist, g_phist;

  gshare_predictor #(.INDEX_WIDTH(6), .OFFSET(2), .COUNTER_WIDTH(2),
                     .HISTORY_WIDTH(0), .TAG_WIDTH(8)) dut_bm (
    .clock(clk), .reset(rst), .addressToPredict(b_pa), .prediction(b_pred),
    .predictHistory(b_phist), .ready(b_ready), .updateEnable(b_en),
    .addressToWrite(b_wa), .updateHistory(b_hist), .branchoutcome(b_out),
    .branchTarget(b_tgt), .predictedTarget(b_ptgt), .targetHit(b_hit));

  gshare_predictor #(.INDEX_WIDTH(6), .OFFSET(2), .COUNTER_WIDTH(2),
                     .HISTORY_WIDTH(6), .TAG_WIDTH(8)) dut (
    .clock(clk), .reset(rst), .addressToPredict(g_pa), .prediction(g_pred),
    .predictHistory(g_phist), .ready(g_ready), .updateEnable(g_en),
    .addressToWrite(g_wa), .updateHistory(g_hist), .branchoutcome(g_out),
    .branchTarget(g_tgt), .predictedTarget(g_ptgt), .targetHit(g_hit));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    int          field;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push_exp(input string name, input int sel, input int field, input logic [31:0] v);
    exp_t e;
    e.name = name; e.sel = sel; e.field = field; e.exp = v;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] actual(input int sel, input int field);
    logic [31:0] r;
    r = 32'hdead_beef;
    case (field)
      F_READY: r = (sel == 0) ? 32'(b_ready) : 32'(g_ready);
      F_PRED:  r = (sel == 0) ? 32'(b_pred)  : 32'(g_pred);
      F_HIST:  r = (sel == 0) ? 32'(b_phist) : 32'(g_phist);
      F_HIT:   r = (sel == 0) ? 32'(b_hit)   : 32'(g_hit);
      F_TGT:   r = (sel == 0) ? b_ptgt       : g_ptgt;
      default: r = 32'hdead_beef;
    endcase
    return r;
  endfunction

  // Monitor: outputs are combinational, so every queued expectation is due at this negedge.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] a;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = actual(e.sel, e.field);
      checks++;
      if (a !== e.exp) begin
        errors++;
        $display("FAIL %s (dut%0d): got 0x%0h, expected 0x%0h", e.name, e.sel, a, e.exp);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Bimodal saturation sequence at PC 0x40: prediction sampled before each update lands.
  bit sat_en  [12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0};
  bit sat_out [12] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0};
  bit sat_exp [12] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};

  // Gshare aliasing sequence at PC 0x100 (PC index bits are 0, so index = history).
  bit         al_en   [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  bit         al_out  [10] = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 0};
  logic [5:0] al_hist [10] = '{6'd0, 6'd0, 6'd1, 6'd1, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'd0};
  bit         al_pexp [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  logic [5:0] al_gexp [10] = '{6'd0, 6'd1, 6'd3, 6'd6, 6'd12, 6'd24, 6'd48, 6'd32, 6'd0, 6'd1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    b_pa = 0; b_wa = 0; b_tgt = 0; b_en = 0; b_out = 0; b_hist = 0;
    g_pa = 0; g_wa = 0; g_tgt = 0; g_en = 0; g_out = 0; g_hist = 0;
    repeat (2) cyc();

    // Reset values on both instances
    for (int s = 0; s < 2; s++) begin
      push_exp("rst_ready", s, F_READY, 32'd0);
      push_exp("rst_pred",  s, F_PRED,  32'd0);
      push_exp("rst_hist",  s, F_HIST,  32'd0);
      push_exp("rst_hit",   s, F_HIT,   32'd0);
      push_exp("rst_tgt",   s, F_TGT,   32'd0);
    end
    rst = 1'b0;

    // First sweep, interrupted by reset after 30 edges
    for (int k = 1; k <= 30; k++) begin
      cyc();
      push_exp($sformatf("sweep1_ready_%0d", k), 1, F_READY, 32'd0);
      push_exp($sformatf("sweep1_pred_%0d", k),  1, F_PRED,  32'd0);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    // Updates offered during INIT must be ignored
    g_en = 1'b1; g_out = 1'b1; b_en = 1'b1; b_out = 1'b1;

    // Restarted sweep: ready exactly at the 64th edge after reset falls
    for (int k = 1; k <= 64; k++) begin
      cyc();
      if (k == 64) begin
        g_en = 1'b0; b_en = 1'b0;
      end
      push_exp($sformatf("sweep2_ready_%0d", k), 0, F_READY, 32'(k == 64));
      push_exp($sformatf("sweep2_ready_%0d", k), 1, F_READY, 32'(k == 64));
      push_exp($sformatf("sweep2_pred_%0d", k),  1, F_PRED,  32'd0);
    end
    push_exp("init_ignore_hist", 1, F_HIST, 32'd0);
    push_exp("init_ignore_pred", 0, F_PRED, 32'd0);

    // Bimodal saturation, includes read-during-write steps
    b_pa = 32'h40; b_wa = 32'h40;
    for (int i = 0; i < 12; i++) begin
      b_en = sat_en[i]; b_out = sat_out[i];
      push_exp($sformatf("sat_step%0d", i), 0, F_PRED, 32'(sat_exp[i]));
      push_exp($sformatf("sat_hist%0d", i), 0, F_HIST, 32'd0);
      cyc();
    end
    b_en = 1'b0;

    // Gshare history split and GHR shift tracking
    g_pa = 32'h100; g_wa = 32'h100; g_tgt = 32'h0;
    for (int i = 0; i < 10; i++) begin
      g_en = al_en[i]; g_out = al_out[i]; g_hist = al_hist[i];
      push_exp($sformatf("alias_pred%0d", i), 1, F_PRED, 32'(al_pexp[i]));
      push_exp($sformatf("alias_ghr%0d", i),  1, F_HIST, 32'(al_gexp[i]));
      cyc();
    end
    g_en = 1'b0;

    // BTB install at 0x200, then hit and tag-mismatch miss
    g_pa = 32'h200; g_wa = 32'h200; g_en = 1'b1; g_out = 1'b1; g_tgt = 32'h800; g_hist = 6'd0;
    push_exp("btb_pre_hit", 1, F_HIT, 32'd0);
    push_exp("btb_pre_tgt", 1, F_TGT, 32'd0);
    cyc();
    g_en = 1'b0;
    push_exp("btb_hit", 1, F_HIT, BTB_ON ? 32'd1 : 32'd0);
    push_exp("btb_tgt", 1, F_TGT, BTB_ON ? 32'h800 : 32'd0);
    cyc();
    g_pa = 32'h200 + (32'd1 << 8);
    push_exp("btb_miss_hit", 1, F_HIT, 32'd0);
    push_exp("btb_miss_tgt", 1, F_TGT, 32'd0);
    cyc();

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised successor to the per-PC two-bit branch predictor in the fetch stage. It XORs a global history register into the pattern-history-table (PHT) index (gshare) and supports a configurable saturating-counter width. An optional branch target buffer (BTB) returns the predicted target alongside the direction. Fetch reads the prediction combinationally; the execute stage writes back resolved outcomes.

## Interface
- `INDEX_WIDTH`, 6: log2 of PHT/BTB entries.
- `OFFSET`, 2: low PC bits dropped before indexing.
- `COUNTER_WIDTH`, 2: saturating counter width, legal range 1..4.
- `HISTORY_WIDTH`, 6: global history bits, legal range 0..INDEX_WIDTH; 0 gives a pure bimodal predictor.
- `TAG_WIDTH`, 8: BTB tag bits.
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `addressToPredict`, in, 32: fetch PC.
- `prediction`, out, 1: predicted taken.
- `predictHistory`, out, HISTORY_WIDTH: GHR value used for this prediction. Fetch carries it down the pipe with the branch.
- `ready`, out, 1: tables initialised.
- `updateEnable`, in, 1: resolved branch this cycle.
- `addressToWrite`, in, 32: PC of the resolved branch.
- `updateHistory`, in, HISTORY_WIDTH: `predictHistory` captured for that branch.
- `branchoutcome`, in, 1: 1 = taken.
- `branchTarget`, in, 32: resolved taken target (BTB only).
- `predictedTarget`, out, 32: BTB target (BTB only).
- `targetHit`, out, 1: BTB hit (BTB only).

## Operation
- **Prediction index:** `addressToPredict[INDEX_WIDTH+OFFSET-1:OFFSET]` XOR the GHR, with the GHR zero-extended to INDEX_WIDTH.
- **Update index:** same formula, using `addressToWrite` and `updateHistory`.
- **Prediction output:** `prediction` is the MSB of the indexed counter, gated by `ready`.
- **Counter update:** applied when `updateEnable && ready`.
  - Taken: increment, saturating at 2^COUNTER_WIDTH-1.
  - Not taken: decrement, saturating at 0.
- **GHR update:** on each accepted update, GHR <= {GHR[HISTORY_WIDTH-2:0], branchoutcome}. The GHR is non-speculative. When HISTORY_WIDTH=0 the GHR is absent and `predictHistory` is unused.
- **State machine:** two states, INIT and RUN.
  - `reset` high: state <= INIT, sweepIndex <= 0, GHR <= 0.
  - INIT, each cycle: write counter[sweepIndex] <= 0 (strongly not taken) and clear BTB valid[sweepIndex], then increment sweepIndex.
  - INIT, at sweepIndex = 2^INDEX_WIDTH-1: the clear completes and state <= RUN.
  - RUN: holds until the next `reset`.
- **Behaviour during INIT:**
  - `ready` = 0, `prediction` = 0, `targetHit` = 0, `predictedTarget` = 0.
  - `updateEnable` is ignored; neither the counters nor the GHR change.
- **Reset mid-sweep:** the sweep restarts at index 0.
- **Reset values:** `ready` 0, `prediction` 0, `predictHistory` 0, `targetHit` 0, `predictedTarget` 0.
- **Read during write:**
  - A prediction read to the same index as an update in the same cycle returns the pre-update value.
  - Two updates never collide, because there is one write port.
- **Wrap-around:** index arithmetic is modulo 2^INDEX_WIDTH. The XOR never carries.

## Timing
- Prediction is combinational from `addressToPredict` and the GHR: zero-cycle latency.
- An update is visible to predictions on the cycle after the `updateEnable` edge. The GHR shift follows the same rule.
- `ready` rises exactly 2^INDEX_WIDTH rising edges after the first edge at which `reset` is sampled low. With INDEX_WIDTH=6 that is 64 edges.

## Configuration
- Macro: `GSHARE_PREDICTOR_BTB_EN`.
- **Defined:** the BTB is compiled in.
  - Storage: 2^INDEX_WIDTH entries, each {valid, tag, target}.
  - BTB index: PC bits only; no history is applied.
  - Tag: `addr[OFFSET+INDEX_WIDTH+TAG_WIDTH-1:OFFSET+INDEX_WIDTH]`.
  - Write: an accepted taken update writes valid=1, the tag and `branchTarget`. A not-taken update leaves the entry unchanged.
  - Read: `targetHit` = valid && tag match; `predictedTarget` = the stored target on a hit, otherwise 0.
- **Undefined:** no BTB storage exists. `branchTarget` is ignored, and `targetHit` and `predictedTarget` are tied to 0.

## Structure
- **Shared package `branch_pred_pkg`:**
  - State enum {INIT, RUN}.
  - Function `sat_update(counter, taken, width)`.
  - Constant for the counter reset value (0).
- **Sub-module `btb_array`:** holds the BTB storage, sweep-clear input, and tag compare. It is instantiated only under `GSHARE_PREDICTOR_BTB_EN`.
- **Top level:** owns the PHT, GHR and FSM.

## Test plan
- **Reset sweep:** assert `reset` mid-sweep at cycle 30 of INIT. Required: sweep restarts; `ready` = 1 exactly 64 edges after `reset` falls; `prediction` = 0 throughout.
- **Counter saturation (taken):** COUNTER_WIDTH=2, HISTORY_WIDTH=0. Apply 4 taken updates to PC 0x40. Required: `prediction` at 0x40 goes 0,0,1,1,1; the counter saturates at 3.
- **Counter saturation (not taken):** after the taken case, apply 2 not-taken updates. Required: `prediction` is 1 then 0; further not-taken updates hold the counter at 0.
- **History aliasing split:** HISTORY_WIDTH=6. Train PC 0x100 taken with `updateHistory`=0, and not taken with `updateHistory`=6'b000001. Required: predictions at the two GHR values differ, and the GHR shifts in each outcome.
- **Read/write same cycle:** predict and update the same index in one cycle. Required: the old prediction appears that cycle and the new value the next cycle.
- **BTB hit/miss (macro defined):** taken update at PC 0x200 with target 0x800. Required: `targetHit`=1 and `predictedTarget`=0x800 at 0x200; `targetHit`=0 at 0x200+(1<<(OFFSET+INDEX_WIDTH)), a tag mismatch.
